i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 267 ++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target: synchronised SCL/SDA edge detection, 7-bit addressing, write/read byte loops with ACK.
// Optional 10-bit addressing is enabled by defining I2C_TARGET_ADDR10_EN.
module i2c_target #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [9:0] own_addr,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
`ifdef I2C_TARGET_ADDR10_EN
        ADDR2,
        ADDR2_ACK,
`endif
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    // Line synchronisers plus one history flop each for edge detection
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign sda_rise  = sda_s & ~sda_prev_q;
    assign sda_fall  = ~sda_s & sda_prev_q;
    assign start_det = sda_fall & scl_s & scl_prev_q;
    assign stop_det  = sda_rise & scl_s & scl_prev_q;

    state_t           state_q, state_d, ack_next_q, ack_next_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d, rx_data_q, rx_data_d;
    logic             sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic             rx_valid_q, rx_valid_d, tx_load_q, tx_load_d;
`ifdef I2C_TARGET_ADDR10_EN
    logic             addr10_match_q, addr10_match_d;
`endif

    // Address byte decode: whether to ACK and which state follows the ACK
    logic   addr_hit_c;
    state_t ack_tgt_c;
`ifdef I2C_TARGET_ADDR10_EN
    always_comb begin
        addr_hit_c = (shift_q[7:1] == own_addr[6:0]);
        ack_tgt_c  = shift_q[0] ? RD_DATA : WR_DATA;
        if (shift_q[7:3] == 5'b11110) begin
            addr_hit_c = (shift_q[2:1] == own_addr[9:8]) && (!shift_q[0] || addr10_match_q);
            ack_tgt_c  = shift_q[0] ? RD_DATA : ADDR2;
        end
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^own_addr[9:7];
    assign addr_hit_c = (shift_q[7:1] == own_addr[6:0]);
    assign ack_tgt_c  = shift_q[0] ? RD_DATA : WR_DATA;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ack_next_q     <= IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            sda_oe_q       <= 1'b0;
            busy_q         <= 1'b0;
            rx_valid_q     <= 1'b0;
            tx_load_q      <= 1'b0;
`ifdef I2C_TARGET_ADDR10_EN
            addr10_match_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            ack_next_q     <= ack_next_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            sda_oe_q       <= sda_oe_d;
            busy_q         <= busy_d;
            rx_valid_q     <= rx_valid_d;
            tx_load_q      <= tx_load_d;
`ifdef I2C_TARGET_ADDR10_EN
            addr10_match_q <= addr10_match_d;
`endif
        end
    end

    // Next-state logic; SDA drive only ever changes on an SCL falling edge
    logic load_rd;
    always_comb begin
        state_d    = state_q;
        ack_next_d = ack_next_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        load_rd    = 1'b0;
`ifdef I2C_TARGET_ADDR10_EN
        addr10_match_d = addr10_match_q;
`endif
        if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
`ifdef I2C_TARGET_ADDR10_EN
            addr10_match_d = 1'b0;
`endif
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
                        bit_cnt_d = '0;
                        if (addr_hit_c) begin
                            sda_oe_d   = 1'b1;
                            busy_d     = 1'b1;
                            ack_next_d = ack_tgt_c;
                            state_d    = ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ack_next_q;
                        load_rd   = (ack_next_q == RD_DATA);
                    end
                end
`ifdef I2C_TARGET_ADDR10_EN
                ADDR2: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
                        bit_cnt_d = '0;
                        if (shift_q == own_addr[7:0]) begin
                            sda_oe_d       = 1'b1;
                            addr10_match_d = 1'b1;
                            state_d        = ADDR2_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR2_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = WR_DATA;
                    end
                end
`endif
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == CNT_W'(8)) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                RD_ACK: begin
                    // bit_cnt marks a controller ACK seen; the reload waits for the next fall
                    if (scl_rise) begin
                        if (sda_s) state_d = WAIT_STOP;
                        else       bit_cnt_d = CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == CNT_W'(1)) begin
                        load_rd = 1'b1;
                    end
                end
                IDLE, WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    sda_oe_d = 1'b0;
                    state_d  = IDLE;
                end
            endcase
            if (load_rd) begin
                state_d   = RD_DATA;
                shift_d   = tx_data;
                tx_load_d = 1'b1;
                sda_oe_d  = ~tx_data[7];
                bit_cnt_d = CNT_W'(1);
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_load  = tx_load_q;

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: bus-master tasks push expectations, a negedge monitor pops and compares.
module tb_i2c_target;
    localparam int unsigned Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv, sda_drv, sda_line;
    logic       sda_oe, tx_load, rx_valid, busy;
    logic [9:0] own_addr;
    logic [7:0] tx_data, rx_data;

    assign sda_line = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_drv),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .own_addr (own_addr),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_bus[$];
    string      exp_name[$];
    logic [7:0] obs_bus[$];

    logic watch = 1'b0, oe_seen = 1'b0, busy_seen = 1'b0, oe_prev = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_data, 8'hxx);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (tx_load) begin
                if (exp_tx.size() == 0) check("tx_load_unexpected", tx_data, 8'hxx);
                else check("tx_load_data", tx_data, exp_tx.pop_front());
            end
            if (sda_oe && !oe_prev) check("oe_rise_while_scl_high", {7'b0, scl_drv}, 8'h00);
        end
        while (obs_bus.size() > 0) check(exp_name.pop_front(), obs_bus.pop_front(), exp_bus.pop_front());
        if (watch) begin
            if (sda_oe) oe_seen = 1'b1;
            if (busy)   busy_seen = 1'b1;
        end
        oe_prev = sda_oe;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        if (!scl_drv) begin
            sda_drv = 1'b1; wait_q();
            scl_drv = 1'b1; wait_q();
        end
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_drv = b; wait_q();
        scl_drv = 1'b1; wait_q();
        s = sda_line; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic send_byte(input string name, input logic [7:0] d, input logic exp_ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        exp_name.push_back(name);
        exp_bus.push_back({7'b0, exp_ack});
        bus_bit(1'b1, s);
        obs_bus.push_back({7'b0, s});
    endtask

    task automatic read_byte(input string name, input logic [7:0] exp_d, input logic ack);
        logic [7:0] r;
        logic       s;
        exp_name.push_back(name);
        exp_bus.push_back(exp_d);
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            r[i] = s;
        end
        obs_bus.push_back(r);
        bus_bit(!ack, s);
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        check({name, "_rx_left"}, 8'(exp_rx.size()), 8'h00);
        check({name, "_tx_left"}, 8'(exp_tx.size()), 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic s;
        rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
        own_addr = 10'h050; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_sda_oe", {7'b0, sda_oe}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_rx_valid", {7'b0, rx_valid}, 8'h00);
        check("rst_tx_load", {7'b0, tx_load}, 8'h00);
        check("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 7-bit write of one byte
        exp_rx.push_back(8'h3C);
        bus_start();
        send_byte("wr_addr_ack", 8'hA0, 1'b0);
        check("wr_busy_after_addr", {7'b0, busy}, 8'h01);
        send_byte("wr_data_ack", 8'h3C, 1'b0);
        bus_stop();
        check("wr_busy_after_stop", {7'b0, busy}, 8'h00);
        drain("wr");

        // 7-bit read of two bytes, then clocks ignored in WAIT_STOP
        tx_data = 8'h96;
        exp_tx.push_back(8'h96);
        exp_tx.push_back(8'h96);
        bus_start();
        send_byte("rd_addr_ack", 8'hA1, 1'b0);
        read_byte("rd_byte0", 8'h96, 1'b1);
        read_byte("rd_byte1", 8'h96, 1'b0);
        check("rd_oe_after_nack", {7'b0, sda_oe}, 8'h00);
        check("rd_busy_before_stop", {7'b0, busy}, 8'h01);
        send_byte("rd_wait_stop_ignored", 8'h00, 1'b1);
        bus_stop();
        check("rd_busy_after_stop", {7'b0, busy}, 8'h00);
        drain("rd");

        // Address mismatch: nothing driven, no busy
        oe_seen = 1'b0; busy_seen = 1'b0; watch = 1'b1;
        bus_start();
        send_byte("mis_addr_nack", 8'hA2, 1'b1);
        send_byte("mis_data_nack", 8'h11, 1'b1);
        bus_stop();
        watch = 1'b0;
        check("mis_oe_seen", {7'b0, oe_seen}, 8'h00);
        check("mis_busy_seen", {7'b0, busy_seen}, 8'h00);
        drain("mis");

`ifdef I2C_TARGET_ADDR10_EN
        // 10-bit: write header, low address, repeated START, read header, one byte
        own_addr = 10'h2C5; tx_data = 8'hA7;
        exp_tx.push_back(8'hA7);
        bus_start();
        send_byte("a10_hdr_w_ack", 8'hF4, 1'b0);
        send_byte("a10_lo_ack", 8'hC5, 1'b0);
        bus_start();
        send_byte("a10_hdr_r_ack", 8'hF5, 1'b0);
        read_byte("a10_rd_byte", 8'hA7, 1'b0);
        bus_stop();
        check("a10_busy_after_stop", {7'b0, busy}, 8'h00);
        drain("a10");
        own_addr = 10'h050;
`else
        // 11110xx header treated as an ordinary 7-bit address
        own_addr = 10'h07B;
        exp_rx.push_back(8'h5A);
        bus_start();
        send_byte("a7hi_addr_ack", 8'hF6, 1'b0);
        send_byte("a7hi_data_ack", 8'h5A, 1'b0);
        bus_stop();
        drain("a7hi");
        own_addr = 10'h050;
`endif

        // STOP after 4 data bits of a write
        bus_start();
        send_byte("abort_addr_ack", 8'hA0, 1'b0);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_busy", {7'b0, busy}, 8'h00);
        check("abort_oe", {7'b0, sda_oe}, 8'h00);
        wait_q();
        drain("abort");

        // Reset pulse while the target drives a read bit
        tx_data = 8'h00;
        exp_tx.push_back(8'h00);
        bus_start();
        send_byte("rstrd_addr_ack", 8'hA1, 1'b0);
        check("rstrd_oe_driving", {7'b0, sda_oe}, 8'h01);
        rst = 1'b1;
        #1;
        check("rstrd_oe_in_reset", {7'b0, sda_oe}, 8'h00);
        check("rstrd_busy_in_reset", {7'b0, busy}, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        oe_seen = 1'b0; watch = 1'b1;
        for (int i = 0; i < 8; i++) bus_bit(1'b1, s);
        bus_stop();
        watch = 1'b0;
        check("rstrd_oe_after_release", {7'b0, oe_seen}, 8'h00);
        drain("rstrd");

        repeat (3) @(negedge clk);
        check("bus_obs_left", 8'(obs_bus.size()), 8'h00);
        check("bus_exp_left", 8'(exp_bus.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
